// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
//   ADDR_W_DEF / INSTR_W_DEF : default PC and instruction widths
//   NOP_INSTR                : canonical RV32I NOP (addi x0,x0,0)
//   ifq_state_e              : fetch request FSM states
package riscv_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs for the fetch queue.
// The head entry sits in a dedicated output register, so dout holds its
// last value whenever the FIFO drains or is cleared.
//   clk, rst : clock, synchronous active-high reset
//   clear    : drop all entries (branch flush), priority over push/pop
//   push     : write din at the tail
//   pop      : consume the head (ignored when empty)
//   load     : load din into the head register without queuing it
//              (used for a word handed straight to decode while empty)
//   din      : entry to write
//   dout     : head entry
//   count    : number of stored entries (0..DEPTH)
//   empty    : count == 0
module ifq_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rd_nxt = rd_ptr + 1'b1;

  // Storage array carries no reset; only pointers and count do.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_nxt;

      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Keep the head register equal to the entry at rd_ptr after the edge.
      // With exactly one entry left, a simultaneous push becomes the new head.
      if (do_pop) begin
        if (count > CW'(1))  dout <= mem[rd_nxt];
        else if (push)       dout <= din;
      end else if ((push || load) && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage between the PC counter and decode.
// Issues one instruction-memory read at a time, queues returned words with
// their PC, hands them to decode over valid/ready and stalls the PC counter
// whenever no new request can be issued. A branch flush empties the queue
// and turns any in-flight read into a discarded one.
//   clk, rst        : clock, synchronous active-high reset
//   pc_in           : current PC from the counter
//   flush           : branch taken, drop everything older
//   pc_stall        : counter must hold PC this cycle
//   imem_req/addr   : read request (held until imem_ack) and its address
//   imem_ack/rdata  : read completion and instruction word
//   dec_valid/instr/pc/ready : decode handshake for the head instruction
// Optional feature: define IFQ_BYPASS_EN to forward a returning word
// straight to decode in the ack cycle when the queue is empty and decode
// is ready.
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               flush,
  output logic               pc_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  ifq_state_e          state;
  ifq_state_e          state_nxt;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic [EW-1:0]       fifo_dout;
  logic [CW:0]         occupancy;
  logic                busy;
  logic                credit;
  logic                issue;
  logic                ack_live;
  logic                bypass;
  logic                push;
  logic                pop;

  // A slot is reserved for the read in flight, so the queue can never
  // overflow when it returns.
  assign busy      = (state != IDLE);
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, busy};
  assign credit    = (occupancy < (CW+1)'(DEPTH));
  assign issue     = !rst && (state == IDLE) && !flush && credit;
  assign pc_stall  = !issue;
  assign imem_req  = busy;

  // Only an ack for a live (non-discarded) request carries a usable word.
  assign ack_live = !rst && (state == WAIT) && imem_ack;

`ifdef IFQ_BYPASS_EN
  assign bypass = ack_live && !flush && dec_ready && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = ack_live && !flush && !bypass;
  assign pop  = dec_ready && !fifo_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = WAIT;
      WAIT: begin
        if (imem_ack)   state_nxt = IDLE;
        else if (flush) state_nxt = DISCARD;
      end
      DISCARD: if (imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_addr <= '0;
    end else begin
      state <= state_nxt;
      if (issue) imem_addr <= pc_in;
    end
  end

  ifq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .load  (bypass),
    .din   ({imem_addr, imem_rdata}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

`ifdef IFQ_BYPASS_EN
  assign dec_valid = !fifo_empty || bypass;
  assign dec_pc    = bypass ? imem_addr  : fifo_dout[EW-1:INSTR_W];
  assign dec_instr = bypass ? imem_rdata : fifo_dout[INSTR_W-1:0];
`else
  assign dec_valid = !fifo_empty;
  assign dec_pc    = fifo_dout[EW-1:INSTR_W];
  assign dec_instr = fifo_dout[INSTR_W-1:0];
`endif

endmodule
